cic_capture_ctrl: RTL and testbench

//   Sequencer for the PDM CIC decimator: holds the CIC in reset between captures, tracks its decimation

---
 rtl/cic_capture_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_cic_capture_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_capture_ctrl.sv
// Capture sequencer for the PDM CIC decimator: CIC reset control, sample strobe recovery, settle discard, 4-deep output FIFO.
// Optional build macro CAP_CTRL_OFFSET_EN adds an offset input subtracted from every pushed sample.
module cic_capture_ctrl #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DECIMATION     = 256,
  parameter int unsigned SETTLE_SAMPLES = 64,
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_samples,
  output logic             cic_rst_n,
  input  logic [WIDTH-1:0] cic_data,
`ifdef CAP_CTRL_OFFSET_EN
  input  logic [WIDTH-1:0] offset,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned PH_W  = $clog2(DECIMATION);
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FC_W  = 3;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SETTLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             cic_rst_n_q, cic_rst_n_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop, push;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] sample;

`ifdef CAP_CTRL_OFFSET_EN
  assign sample = WIDTH'(cic_data - offset);
`else
  assign sample = cic_data;
`endif

  // Next-state, sample strobe and shift-register FIFO (entry 0 is the head)
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    phase_d     = phase_q;
    cic_rst_n_d = cic_rst_n_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    mem_d       = mem_q;
    push        = 1'b0;
    wr_idx      = '0;
    pop         = valid_q & out_ready;

    if (cic_rst_n_q) begin
      phase_d = (phase_q == PH_W'(DECIMATION - 1)) ? '0 : phase_q + PH_W'(1);
    end
    tick_d = cic_rst_n_q && (phase_q == PH_W'(DECIMATION - 1));

    case (state_q)
      S_IDLE: begin
        cic_rst_n_d = 1'b0;
        if (start) begin
          num_d      = num_samples;
          overflow_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          cic_rst_n_d = 1'b1;
          phase_d     = '0;
          cnt_d       = '0;
          state_d     = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (tick_q) begin
          if (cnt_q == CNT_W'(SETTLE_SAMPLES - 1)) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (stop) begin
          cic_rst_n_d = 1'b0;
          state_d     = S_DRAIN;
        end
      end
      S_RUN: begin
        if (tick_q) begin
          if ((fcnt_q < FC_W'(DEPTH)) || pop) begin
            push  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if ((num_q != '0) && ((cnt_q + CNT_W'(1)) == num_q)) begin
              cic_rst_n_d = 1'b0;
              state_d     = S_DRAIN;
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (stop) begin
          cic_rst_n_d = 1'b0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cic_rst_n_d = 1'b0;
        if (fcnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
    end
    if (push) begin
      wr_idx        = IDX_W'(fcnt_q - FC_W'(pop));
      mem_d[wr_idx] = sample;
    end
    fcnt_d  = fcnt_q + FC_W'(push) - FC_W'(pop);
    valid_d = (fcnt_d != '0);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      phase_q     <= '0;
      tick_q      <= 1'b0;
      cic_rst_n_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      fcnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      cic_rst_n_q <= cic_rst_n_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      fcnt_q      <= fcnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign cic_rst_n = cic_rst_n_q;
  assign out_data  = mem_q[0];
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cic_capture_ctrl.sv
// Bench for cic_capture_ctrl: scenario table plus hand sequences, checked every cycle against an event-time model.
// Define CAP_CTRL_OFFSET_EN to exercise the offset port.
module tb_cic_capture_ctrl;

  localparam int W = 16;
  localparam int D = 4;
  localparam int S = 2;
  localparam int F = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop;
  logic [15:0]  num_samples;
  logic         cic_rst_n;
  logic [W-1:0] cic_data;
`ifdef CAP_CTRL_OFFSET_EN
  logic [W-1:0] offset;
`endif
  logic [W-1:0] out_data;
  logic         out_valid, out_ready, busy, done, overflow;

  always #5 clk = ~clk;

  cic_capture_ctrl #(
    .WIDTH(W), .DECIMATION(D), .SETTLE_SAMPLES(S), .FLUSH_CYCLES(F), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_samples(num_samples),
    .cic_rst_n(cic_rst_n), .cic_data(cic_data),
`ifdef CAP_CTRL_OFFSET_EN
    .offset(offset),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  bit hold_data = 1'b0;

  // Reference: mode 0 idle, 1 flush, 2 settle, 3 run, 4 drain; samples taken at fixed offsets from the CIC release edge
  int          m_mode, m_e, m_start_e, m_rise_e, m_disc, m_pushed, m_run_ticks, m_num;
  bit          m_ovf, m_done;
  logic [W-1:0] m_q[$];

  typedef struct {
    int num; int rmode; int stop_t; int restart_t; int rst_t;
    int exp_deliv; int exp_ovf; int exp_done;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_e = 0; m_ovf = 1'b0; m_done = 1'b0;
    m_q.delete();
  endtask

  function automatic bit tick_at(input int e);
    int d = e - m_rise_e;
    return (m_mode == 2 || m_mode == 3) && (d > D) && (((d - 1) % D) == 0);
  endfunction

  task automatic model_step();
    int sz0 = m_q.size();
    bit tick;
    m_e++;
    m_done = 1'b0;
    tick = tick_at(m_e);
    if (sz0 > 0 && out_ready) void'(m_q.pop_front());
    case (m_mode)
      0: if (start) begin
        m_num = int'(num_samples); m_ovf = 1'b0; m_disc = 0; m_pushed = 0; m_run_ticks = 0;
        m_start_e = m_e; m_mode = 1;
      end
      1: if (stop) m_mode = 4;
         else if (m_e == m_start_e + F) begin m_rise_e = m_e; m_mode = 2; end
      2: begin
        if (tick) begin m_disc++; if (m_disc == S) m_mode = 3; end
        if (stop) m_mode = 4;
      end
      3: begin
        if (tick) begin
          m_run_ticks++;
          if (m_q.size() < 4) begin
`ifdef CAP_CTRL_OFFSET_EN
            m_q.push_back(W'(cic_data - offset));
`else
            m_q.push_back(cic_data);
`endif
            m_pushed++;
            if (m_num != 0 && m_pushed == m_num) m_mode = 4;
          end else m_ovf = 1'b1;
        end
        if (stop) m_mode = 4;
      end
      4: if (sz0 == 0) begin m_done = 1'b1; m_mode = 0; end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_all();
    chk("cic_rst_n", 32'(cic_rst_n), 32'(m_mode == 2 || m_mode == 3));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (!hold_data) begin
      cic_data = W'($urandom);
`ifdef CAP_CTRL_OFFSET_EN
      offset = W'($urandom);
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_cic_rst_n", 32'(cic_rst_n), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, output int deliv, output int dones);
    bit stopped = 1'b0, restarted = 1'b0, fin = 1'b0;
    deliv = 0; dones = 0;
    start = 1'b1; stop = 1'b0; num_samples = 16'(v.num);
    out_ready = (v.rmode == 0);
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (out_valid && out_ready) deliv++;
      step();
      start = 1'b0; stop = 1'b0;
      num_samples = 16'($urandom);
      if (done) begin dones++; fin = 1'b1; end
      if (v.rst_t != 0 && m_mode == 3 && m_run_ticks == v.rst_t) begin do_reset(); fin = 1'b1; end
      if (v.stop_t != 0 && !stopped && m_mode == 3 && tick_at(m_e + 1) && m_run_ticks + 1 == v.stop_t) begin
        stop = 1'b1; stopped = 1'b1;
      end
      if (v.restart_t != 0 && !restarted && m_mode == 3 && m_run_ticks == v.restart_t) begin
        start = 1'b1; restarted = 1'b1;
      end
      case (v.rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = stopped && !stop;
        2:       out_ready = ($urandom % 4) != 0;
        default: out_ready = ($urandom % 4) == 0;
      endcase
    end
    if (!fin) chk("scenario_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int deliv, dones, seen;
    //         num rmode stop restart rst  deliv ovf done
    vecs[0] = '{3,  0,    0,   0,      0,   3,    0,  1};
    vecs[1] = '{6,  1,    6,   0,      0,   4,    1,  1};
    vecs[2] = '{0,  0,    5,   0,      0,   5,    0,  1};
    vecs[3] = '{1,  0,    0,   0,      0,   1,    0,  1};
    vecs[4] = '{5,  2,    0,   0,      0,   5,    2,  1};
    vecs[5] = '{3,  0,    0,   1,      0,   3,    0,  1};
    vecs[6] = '{0,  0,    0,   0,      2,   1,    0,  0};
    vecs[7] = '{10, 3,    0,   0,      0,   10,   2,  1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_samples = '0; out_ready = 1'b0; cic_data = '0;
`ifdef CAP_CTRL_OFFSET_EN
    offset = '0;
`endif
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) step();

    // start and stop together in IDLE: start wins; then abort from FLUSH
    start = 1'b1; stop = 1'b1; num_samples = 16'd3;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_wins_busy", 32'(busy), 32'h1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("flush_abort_cic_rst_n", 32'(cic_rst_n), 32'h0);
    step();
    chk("flush_abort_done", 32'(done), 32'h1);
    step();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], deliv, dones);
      chk($sformatf("vec%0d_delivered", i), 32'(deliv), 32'(vecs[i].exp_deliv));
      chk($sformatf("vec%0d_done_pulses", i), 32'(dones), 32'(vecs[i].exp_done));
      if (vecs[i].exp_ovf != 2) chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
    end

    // fixed CIC output to check the pushed value directly
    hold_data = 1'b1; cic_data = 16'h0005;
`ifdef CAP_CTRL_OFFSET_EN
    offset = 16'h0010;
`endif
    start = 1'b1; num_samples = 16'd1; out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      step();
      start = 1'b0;
      if (out_valid) seen = 1;
    end
`ifdef CAP_CTRL_OFFSET_EN
    chk("fixed_sample_value", 32'(out_data), 32'h0000FFF5);
`else
    chk("fixed_sample_value", 32'(out_data), 32'h00000005);
`endif
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      step();
      if (done) seen = 1;
    end
    chk("fixed_sample_done", 32'(seen), 32'h1);
    hold_data = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
